// File: rtl/sgpio_bp_led_decoder_pkg.sv
// Shared constants and types for the SGPIO backplane LED decoder.
package sgpio_bp_led_decoder_pkg;

  typedef enum logic {
    UNSYNC = 1'b0,
    SHIFT  = 1'b1
  } state_t;

  localparam int unsigned BITS_PER_DRV    = 3;
  localparam int unsigned DEF_HDD_NUM     = 36;
  localparam int unsigned DEF_TIMEOUT_CYC = 50000;

  function automatic int unsigned frame_bits(input int unsigned hdd_num);
    return BITS_PER_DRV * hdd_num;
  endfunction

endpackage

// File: rtl/sgpio_bp_led_decoder_if.sv
// SGPIO serial inputs and per-drive LED / status outputs.
interface sgpio_bp_led_decoder_if
  #(parameter int unsigned HDD_NUM = sgpio_bp_led_decoder_pkg::DEF_HDD_NUM);

  logic               SGPIO_CK;
  logic               SGPIO_LD;
  logic               SGPIO_DATA;
  logic [HDD_NUM-1:0] DRV_ACT_LED;
  logic [HDD_NUM-1:0] DRV_LOC_LED;
  logic [HDD_NUM-1:0] DRV_FAIL_LED;
  logic               LINK_OK;
  logic               FRAME_STB;
  logic [7:0]         FRAME_ERR_CNT;

  modport master (
    output SGPIO_CK, SGPIO_LD, SGPIO_DATA,
    input  DRV_ACT_LED, DRV_LOC_LED, DRV_FAIL_LED, LINK_OK, FRAME_STB, FRAME_ERR_CNT
  );

  modport slave (
    input  SGPIO_CK, SGPIO_LD, SGPIO_DATA,
    output DRV_ACT_LED, DRV_LOC_LED, DRV_FAIL_LED, LINK_OK, FRAME_STB, FRAME_ERR_CNT
  );

endinterface

// File: rtl/sgpio_bp_led_decoder_in_sync.sv
// Two-flop synchronisers for CK/LD/DATA plus CK falling-edge detect.
module sgpio_in_sync (
  input  logic SYSCLK,
  input  logic RESET,
  input  logic SGPIO_CK,
  input  logic SGPIO_LD,
  input  logic SGPIO_DATA,
  output logic CK_FALL,
  output logic LD_S,
  output logic DATA_S
);

  logic [1:0] ck_sync;
  logic [1:0] ld_sync;
  logic [1:0] data_sync;
  logic       ck_dly;

  // Synchroniser chains and edge-detect delay flop.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      ck_sync   <= '0;
      ld_sync   <= '0;
      data_sync <= '0;
      ck_dly    <= 1'b0;
    end else begin
      ck_sync   <= {ck_sync[0], SGPIO_CK};
      ld_sync   <= {ld_sync[0], SGPIO_LD};
      data_sync <= {data_sync[0], SGPIO_DATA};
      ck_dly    <= ck_sync[1];
    end
  end

  assign CK_FALL = ck_dly & ~ck_sync[1];
  assign LD_S    = ld_sync[1];
  assign DATA_S  = data_sync[1];

endmodule

// File: rtl/sgpio_bp_led_decoder.sv
// Backplane-side SGPIO target: deserialises ACT/LOC/FAIL per drive.
module sgpio_bp_led_decoder
  import sgpio_bp_led_decoder_pkg::*;
#(
  parameter int unsigned HDD_NUM     = DEF_HDD_NUM,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic                   SYSCLK,
  input logic                   RESET,
  sgpio_bp_led_decoder_if.slave sgpio
);

  localparam int unsigned FRAME_BITS = frame_bits(HDD_NUM);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYC - 1);

  logic ck_fall;
  logic ld_s;
  logic data_s;

  sgpio_in_sync u_in_sync (
    .SYSCLK     (SYSCLK),
    .RESET      (RESET),
    .SGPIO_CK   (sgpio.SGPIO_CK),
    .SGPIO_LD   (sgpio.SGPIO_LD),
    .SGPIO_DATA (sgpio.SGPIO_DATA),
    .CK_FALL    (ck_fall),
    .LD_S       (ld_s),
    .DATA_S     (data_s)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMR_W-1:0]      timer_q;
  logic [FRAME_BITS-1:0] shadow;
  logic                  store_en;
  logic                  commit_d, commit_q;
  logic                  frame_err;
  logic                  expire;
  logic [HDD_NUM-1:0]    act_next, loc_next, fail_next;

  // Next state, bit counter and event decode; a CK fall takes priority over timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    store_en  = 1'b0;
    commit_d  = 1'b0;
    frame_err = 1'b0;
    expire    = 1'b0;
    if (ck_fall) begin
      case (state_q)
        UNSYNC: begin
          if (ld_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (ld_s) begin
            store_en = 1'b1;
            cnt_d    = '0;
            if (cnt_q == LAST_BIT) commit_d  = 1'b1;
            else                   frame_err = 1'b1;
          end else if (cnt_q == LAST_BIT) begin
            frame_err = 1'b1;
            state_d   = UNSYNC;
            cnt_d     = '0;
          end else begin
            store_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end else if (timer_q == TMR_MAX) begin
      expire  = 1'b1;
      state_d = UNSYNC;
      cnt_d   = '0;
    end
  end

  // State, counter, shadow register and link timer.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q  <= UNSYNC;
      cnt_q    <= '0;
      shadow   <= '0;
      commit_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      if (store_en) shadow[cnt_q] <= data_s;
      if (ck_fall)                timer_q <= '0;
      else if (timer_q != TMR_MAX) timer_q <= timer_q + TMR_W'(1);
    end
  end

  for (genvar i = 0; i < HDD_NUM; i++) begin : g_map
    assign act_next[i]  = shadow[BITS_PER_DRV*i];
    assign loc_next[i]  = shadow[BITS_PER_DRV*i + 1];
    assign fail_next[i] = shadow[BITS_PER_DRV*i + 2];
  end

  // Commit lands one cycle after the closing bit is stored in the shadow.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      sgpio.DRV_ACT_LED   <= '0;
      sgpio.DRV_LOC_LED   <= '0;
      sgpio.DRV_FAIL_LED  <= '0;
      sgpio.LINK_OK       <= 1'b0;
      sgpio.FRAME_STB     <= 1'b0;
      sgpio.FRAME_ERR_CNT <= '0;
    end else begin
      sgpio.FRAME_STB <= commit_q;
      if (commit_q) begin
        sgpio.DRV_ACT_LED  <= act_next;
        sgpio.DRV_LOC_LED  <= loc_next;
        sgpio.DRV_FAIL_LED <= fail_next;
        sgpio.LINK_OK      <= 1'b1;
      end
      if (frame_err) begin
        sgpio.LINK_OK <= 1'b0;
        if (sgpio.FRAME_ERR_CNT != '1) sgpio.FRAME_ERR_CNT <= sgpio.FRAME_ERR_CNT + 8'd1;
      end
      if (expire) begin
        sgpio.DRV_ACT_LED  <= '0;
        sgpio.DRV_LOC_LED  <= '0;
        sgpio.DRV_FAIL_LED <= '0;
        sgpio.LINK_OK      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sgpio_bp_led_decoder.sv
// Self-checking bench for sgpio_bp_led_decoder.
module tb_sgpio_bp_led_decoder;

  localparam int unsigned HDD = 36;
  localparam int unsigned TO  = 300;
  localparam int unsigned NB  = 3 * HDD;
  localparam logic [HDD-1:0] Z   = '0;
  localparam logic [HDD-1:0] ONE = '1;
  localparam logic [HDD-1:0] P_ACT  = 36'h0_0000_0020;
  localparam logic [HDD-1:0] P_FAIL = 36'h8_0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sgpio_bp_led_decoder_if #(.HDD_NUM(HDD)) sg ();

  sgpio_bp_led_decoder #(.HDD_NUM(HDD), .TIMEOUT_CYC(TO)) dut (
    .SYSCLK (clk),
    .RESET  (rst),
    .sgpio  (sg)
  );

  int unsigned cyc = 0;
  int unsigned stb_cnt = 0;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned fall_cyc = 0;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (sg.FRAME_STB === 1'b1) stb_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference model.
  bit             m_sync;
  bit             q[$];
  logic [HDD-1:0] m_act, m_loc, m_fail;
  bit             m_link;
  int unsigned    m_err;
  int unsigned    m_commits;

  function automatic void m_reset();
    m_sync = 0; q.delete(); m_act = '0; m_loc = '0; m_fail = '0;
    m_link = 0; m_err = 0; m_commits = 0;
  endfunction

  function automatic void m_error();
    if (m_err < 255) m_err++;
    m_link = 0;
  endfunction

  function automatic void m_timeout();
    m_act = '0; m_loc = '0; m_fail = '0; m_link = 0; m_sync = 0; q.delete();
  endfunction

  function automatic void m_bit(bit ld, bit d);
    if (!m_sync) begin
      if (ld) begin m_sync = 1; q.delete(); end
      return;
    end
    q.push_back(d);
    if (ld) begin
      if (q.size() == NB) begin
        for (int i = 0; i < HDD; i++) begin
          m_act[i] = q[3*i]; m_loc[i] = q[3*i+1]; m_fail[i] = q[3*i+2];
        end
        m_link = 1;
        m_commits++;
      end else m_error();
      q.delete();
    end else if (q.size() == NB) begin
      m_error();
      m_sync = 0;
      q.delete();
    end
  endfunction

  function automatic bit frame_bit(int unsigned k, logic [HDD-1:0] a, logic [HDD-1:0] l, logic [HDD-1:0] f);
    int unsigned drv = k / 3;
    if (drv >= HDD) return 1'b0;
    case (k % 3)
      0:       return a[drv];
      1:       return l[drv];
      default: return f[drv];
    endcase
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_fall(input bit ld, input bit d);
    sg.SGPIO_CK = 1'b1; sg.SGPIO_LD = ld; sg.SGPIO_DATA = d;
    tick(4);
    sg.SGPIO_CK = 1'b0;
    fall_cyc = cyc;
    m_bit(ld, d);
  endtask

  task automatic send_bit(input bit ld, input bit d);
    send_fall(ld, d);
    tick(4);
  endtask

  task automatic send_frame(input int unsigned len, input bit ld_last,
                            input logic [HDD-1:0] a, input logic [HDD-1:0] l, input logic [HDD-1:0] f);
    for (int unsigned k = 0; k < len; k++)
      send_bit(ld_last && (k == len - 1), frame_bit(k, a, l, f));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_act"},  64'(sg.DRV_ACT_LED),   64'(m_act));
    check({tag, "_loc"},  64'(sg.DRV_LOC_LED),   64'(m_loc));
    check({tag, "_fail"}, 64'(sg.DRV_FAIL_LED),  64'(m_fail));
    check({tag, "_link"}, 64'(sg.LINK_OK),       64'(m_link));
    check({tag, "_err"},  64'(sg.FRAME_ERR_CNT), 64'(m_err));
    check({tag, "_stb"},  64'(stb_cnt),          64'(m_commits));
  endtask

  typedef struct {
    int unsigned    len;
    bit             ld_last;
    logic [HDD-1:0] in_act, in_loc, in_fail;
    logic [HDD-1:0] ex_act, ex_loc, ex_fail;
    bit             ex_link;
    logic [7:0]     ex_err;
    int unsigned    ex_stb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int unsigned    stb0;
    logic [63:0]    r64;
    logic [HDD-1:0] ra, rl, rf;
    int unsigned    kind, len;

    tbl[0] = '{32'd1,   1'b1, Z,     Z,     Z,      Z,     Z,   Z,      1'b0, 8'd0, 32'd0};
    tbl[1] = '{32'd108, 1'b1, P_ACT, Z,     P_FAIL, P_ACT, Z,   P_FAIL, 1'b1, 8'd0, 32'd1};
    tbl[2] = '{32'd61,  1'b1, ONE,   ONE,   ONE,    P_ACT, Z,   P_FAIL, 1'b0, 8'd1, 32'd0};
    tbl[3] = '{32'd108, 1'b1, Z,     ONE,   Z,      Z,     ONE, Z,      1'b1, 8'd1, 32'd1};
    tbl[4] = '{32'd109, 1'b0, ONE,   ONE,   ONE,    Z,     ONE, Z,      1'b0, 8'd2, 32'd0};
    tbl[5] = '{32'd108, 1'b1, 36'h1, Z,     Z,      Z,     ONE, Z,      1'b0, 8'd2, 32'd0};
    tbl[6] = '{32'd108, 1'b1, 36'h1, 36'h2, Z,      36'h1, 36'h2, Z,    1'b1, 8'd2, 32'd1};

    rst = 1'b1;
    sg.SGPIO_CK = 1'b1; sg.SGPIO_LD = 1'b0; sg.SGPIO_DATA = 1'b0;
    m_reset();
    tick(3);
    check("rst_act",  64'(sg.DRV_ACT_LED),   64'd0);
    check("rst_link", 64'(sg.LINK_OK),       64'd0);
    check("rst_stb",  64'(sg.FRAME_STB),     64'd0);
    check("rst_err",  64'(sg.FRAME_ERR_CNT), 64'd0);
    rst = 1'b0;
    tick(2);

    // Reset asserted in the middle of a frame.
    send_frame(1, 1'b1, Z, Z, Z);
    send_frame(NB, 1'b1, 36'hA_BCDE_F012, 36'h3_4567_89AB, 36'hC_0FFE_E123);
    send_frame(5, 1'b1, ONE, ONE, ONE);
    tick(6);
    check("pre_rst_act", 64'(sg.DRV_ACT_LED),   64'h0_000A_BCDE_F012);
    check("pre_rst_err", 64'(sg.FRAME_ERR_CNT), 64'd1);
    send_frame(30, 1'b0, ONE, Z, ONE);
    rst = 1'b1;
    tick(1);
    check("midrst_act",  64'(sg.DRV_ACT_LED),   64'd0);
    check("midrst_loc",  64'(sg.DRV_LOC_LED),   64'd0);
    check("midrst_fail", 64'(sg.DRV_FAIL_LED),  64'd0);
    check("midrst_link", 64'(sg.LINK_OK),       64'd0);
    check("midrst_stb",  64'(sg.FRAME_STB),     64'd0);
    check("midrst_err",  64'(sg.FRAME_ERR_CNT), 64'd0);
    rst = 1'b0;
    m_reset();
    stb_cnt = 0;
    tick(2);

    // Table of frames from a freshly reset decoder.
    for (int i = 0; i < 7; i++) begin
      stb0 = stb_cnt;
      send_frame(tbl[i].len, tbl[i].ld_last, tbl[i].in_act, tbl[i].in_loc, tbl[i].in_fail);
      tick(6);
      check($sformatf("tbl%0d_act", i),  64'(sg.DRV_ACT_LED),   64'(tbl[i].ex_act));
      check($sformatf("tbl%0d_loc", i),  64'(sg.DRV_LOC_LED),   64'(tbl[i].ex_loc));
      check($sformatf("tbl%0d_fail", i), 64'(sg.DRV_FAIL_LED),  64'(tbl[i].ex_fail));
      check($sformatf("tbl%0d_link", i), 64'(sg.LINK_OK),       64'(tbl[i].ex_link));
      check($sformatf("tbl%0d_err", i),  64'(sg.FRAME_ERR_CNT), 64'(tbl[i].ex_err));
      check($sformatf("tbl%0d_stb", i),  64'(stb_cnt - stb0),   64'(tbl[i].ex_stb));
    end

    // Commit latency and strobe width.
    stb0 = stb_cnt;
    for (int unsigned k = 0; k < NB - 1; k++) send_bit(1'b0, frame_bit(k, P_ACT, Z, P_FAIL));
    send_fall(1'b1, frame_bit(NB - 1, P_ACT, Z, P_FAIL));
    tick(3);
    check("lat3_act", 64'(sg.DRV_ACT_LED), 64'h1);
    check("lat3_stb", 64'(sg.FRAME_STB),   64'd0);
    tick(1);
    check("lat4_act",  64'(sg.DRV_ACT_LED),  64'(P_ACT));
    check("lat4_loc",  64'(sg.DRV_LOC_LED),  64'd0);
    check("lat4_fail", 64'(sg.DRV_FAIL_LED), 64'(P_FAIL));
    check("lat4_stb",  64'(sg.FRAME_STB),    64'd1);
    check("lat4_link", 64'(sg.LINK_OK),      64'd1);
    tick(1);
    check("lat5_stb",   64'(sg.FRAME_STB),  64'd0);
    check("lat_stbcnt", 64'(stb_cnt - stb0), 64'd1);

    // Link timeout with CK held low after the last fall.
    while (cyc < fall_cyc + 2 + TO) tick(1);
    check("to_pre_act",  64'(sg.DRV_ACT_LED), 64'(P_ACT));
    check("to_pre_link", 64'(sg.LINK_OK),     64'd1);
    tick(1);
    check("to_act",  64'(sg.DRV_ACT_LED),  64'd0);
    check("to_loc",  64'(sg.DRV_LOC_LED),  64'd0);
    check("to_fail", 64'(sg.DRV_FAIL_LED), 64'd0);
    check("to_link", 64'(sg.LINK_OK),      64'd0);
    m_timeout();
    send_frame(NB, 1'b1, P_ACT, 36'h5, P_FAIL);
    tick(6);
    check("to_resync_act", 64'(sg.DRV_ACT_LED), 64'd0);
    send_frame(NB, 1'b1, P_ACT, 36'h5, P_FAIL);
    tick(6);
    check("to_restore_act",  64'(sg.DRV_ACT_LED),  64'(P_ACT));
    check("to_restore_loc",  64'(sg.DRV_LOC_LED),  64'h5);
    check("to_restore_link", 64'(sg.LINK_OK),      64'd1);

    // Randomised frames against the reference model.
    for (int n = 0; n < 20; n++) begin
      r64 = {$urandom(), $urandom()}; ra = r64[HDD-1:0];
      r64 = {$urandom(), $urandom()}; rl = r64[HDD-1:0];
      r64 = {$urandom(), $urandom()}; rf = r64[HDD-1:0];
      kind = $urandom_range(0, 9);
      if (kind == 6 || kind == 7)  send_frame($urandom_range(1, NB - 1), 1'b1, ra, rl, rf);
      else if (kind == 8)          send_frame($urandom_range(NB, NB + 12), 1'b0, ra, rl, rf);
      else                         send_frame(NB, 1'b1, ra, rl, rf);
      tick(6);
      check_model($sformatf("rnd%0d", n));
    end

    // Error counter saturation.
    for (int n = 0; n < 300; n++) send_bit(1'b1, 1'b0);
    tick(6);
    check("sat_err",  64'(sg.FRAME_ERR_CNT), 64'hFF);
    check("sat_link", 64'(sg.LINK_OK),       64'd0);
    check_model("sat");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
